// File: rtl/retire_trace_collector.sv
// Retire-trace sink: serialises up to two retirements per cycle in program order
// into a sequence-numbered record FIFO drained through a valid/ready stream.
module retire_trace_collector #(
  parameter int DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        _0_valid,
  input  logic [31:0] _0_hartid,
  input  logic [31:0] _0_timer,
  input  logic [31:0] _0_pc,
  input  logic [31:0] _0_inst,
  input  logic        _0_wren,
  input  logic [4:0]  _0_wrdst,
  input  logic [31:0] _0_wrdata,
  input  logic [4:0]  _0_rd0src,
  input  logic [4:0]  _0_rd1src,
  input  logic [31:0] _0_rd0val,
  input  logic [31:0] _0_rd1val,
  input  logic        _1_valid,
  input  logic [31:0] _1_hartid,
  input  logic [31:0] _1_timer,
  input  logic [31:0] _1_pc,
  input  logic [31:0] _1_inst,
  input  logic        _1_wren,
  input  logic [4:0]  _1_wrdst,
  input  logic [31:0] _1_wrdata,
  input  logic [4:0]  _1_rd0src,
  input  logic [4:0]  _1_rd1src,
  input  logic [31:0] _1_rd0val,
  input  logic [31:0] _1_rd1val,
  input  logic        rec_ready,
  output logic        rec_valid,
  output logic [31:0] rec_seq,
  output logic        rec_slot,
  output logic [31:0] rec_hartid,
  output logic [31:0] rec_timer,
  output logic [31:0] rec_pc,
  output logic [31:0] rec_inst,
  output logic        rec_wren,
  output logic [4:0]  rec_wrdst,
  output logic [31:0] rec_wrdata,
  output logic [4:0]  rec_rd0src,
  output logic [4:0]  rec_rd1src,
  output logic [31:0] rec_rd0val,
  output logic [31:0] rec_rd1val,
  output logic [15:0] drop_count,
  output logic        overflow,
  output logic        order_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] seq;
    logic        slot;
    logic [31:0] hartid;
    logic [31:0] timer;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wren;
    logic [4:0]  wrdst;
    logic [31:0] wrdata;
    logic [4:0]  rd0src;
    logic [4:0]  rd1src;
    logic [31:0] rd0val;
    logic [31:0] rd1val;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          head;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   seq_q, seq_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          overflow_q, overflow_d;
  logic          order_err_q, order_err_d;

  logic [1:0]    req;
  logic          grant0, grant1;
  logic [1:0]    grant;
  logic [CW-1:0] free;
  logic          pop;
  logic [1:0]    n_req, n_push, n_drop;
  logic [16:0]   drop_sum;
  rec_t          slot_rec [2];
  logic [AW-1:0] slot_ptr [2];

  always_comb begin
    req    = {en & _1_valid, en & _0_valid};
    // Space is judged on the start-of-cycle count; a same-cycle pop frees nothing.
    free   = DEPTH_C - count_q;
    grant0 = req[0] & (free != '0);
    grant1 = req[1] & (req[0] ? (grant0 & (free > CW'(1))) : (free != '0));
    grant  = {grant1, grant0};
    pop    = (count_q != '0) & rec_ready;

    n_req  = {1'b0, req[0]} + {1'b0, req[1]};
    n_push = {1'b0, grant0} + {1'b0, grant1};
    n_drop = n_req - n_push;

    slot_ptr[0] = wr_ptr_q;
    slot_ptr[1] = wr_ptr_q + AW'(grant0);

    slot_rec[0].seq    = seq_q;
    slot_rec[0].slot   = 1'b0;
    slot_rec[0].hartid = _0_hartid;
    slot_rec[0].timer  = _0_timer;
    slot_rec[0].pc     = _0_pc;
    slot_rec[0].inst   = _0_inst;
    slot_rec[0].wren   = _0_wren & (_0_wrdst != 5'd0);
    slot_rec[0].wrdst  = _0_wrdst;
    slot_rec[0].wrdata = _0_wrdata;
    slot_rec[0].rd0src = _0_rd0src;
    slot_rec[0].rd1src = _0_rd1src;
    slot_rec[0].rd0val = _0_rd0val;
    slot_rec[0].rd1val = _0_rd1val;

    // Slot 1 follows slot 0 in sequence space only when slot 0 actually retired.
    slot_rec[1].seq    = seq_q + 32'(req[0]);
    slot_rec[1].slot   = 1'b1;
    slot_rec[1].hartid = _1_hartid;
    slot_rec[1].timer  = _1_timer;
    slot_rec[1].pc     = _1_pc;
    slot_rec[1].inst   = _1_inst;
    slot_rec[1].wren   = _1_wren & (_1_wrdst != 5'd0);
    slot_rec[1].wrdst  = _1_wrdst;
    slot_rec[1].wrdata = _1_wrdata;
    slot_rec[1].rd0src = _1_rd0src;
    slot_rec[1].rd1src = _1_rd1src;
    slot_rec[1].rd0val = _1_rd0val;
    slot_rec[1].rd1val = _1_rd1val;

    count_d      = count_q + CW'(n_push) - CW'(pop);
    wr_ptr_d     = wr_ptr_q + AW'(n_push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    seq_d        = seq_q + 32'(n_req);
    drop_sum     = {1'b0, drop_count_q} + 17'(n_drop);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d   = overflow_q | (n_drop != 2'd0);
    order_err_d  = order_err_q | (req[1] & ~req[0]);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      seq_q        <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      order_err_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      seq_q        <= seq_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      order_err_q  <= order_err_d;
    end
  end

  // Storage is never reset; reset simply abandons whatever it holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) mem[slot_ptr[i]] <= slot_rec[i];
      end
    end
  end

  assign head       = mem[rd_ptr_q];
  assign rec_valid  = (count_q != '0);
  assign rec_seq    = head.seq;
  assign rec_slot   = head.slot;
  assign rec_hartid = head.hartid;
  assign rec_timer  = head.timer;
  assign rec_pc     = head.pc;
  assign rec_inst   = head.inst;
  assign rec_wren   = head.wren;
  assign rec_wrdst  = head.wrdst;
  assign rec_wrdata = head.wrdata;
  assign rec_rd0src = head.rd0src;
  assign rec_rd1src = head.rd1src;
  assign rec_rd0val = head.rd0val;
  assign rec_rd1val = head.rd1val;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;
  assign order_err  = order_err_q;

endmodule
